alu_md: RTL and testbench

Parametrised execute-stage unit that replaces the single-cycle integer ALU and adds the RV32M/RV64M multiply/divide instructions. It sits between decode/register-read and the memory stage. Base integer and branch-compare operations complete in one cycle. Multiplies use a fixed-latency pipeline and divides use an iterative engine, and a valid/ready handshake stalls decode while a multicycle operation is in flight.

---
 rtl/alu_md.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_md.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// alu_md: execute-stage integer ALU with RV32M/RV64M multiply/divide.
// Ports: CLK/RST; in_valid/in_ready/flush handshake; decode fields
// imm/branch_i/funct3/funct7; operands op1/op2; rd_i/wb_i/side_i
// passthrough; out_valid/res/wb_en_o/rd_o/branch_o/side_o to memory.
module alu_md #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int SIDE_W     = 108
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              imm,
  input  logic              branch_i,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  input  logic [4:0]        rd_i,
  input  logic              wb_i,
  input  logic [SIDE_W-1:0] side_i,
  output logic              out_valid,
  output logic [XLEN-1:0]   res,
  output logic              wb_en_o,
  output logic [4:0]        rd_o,
  output logic              branch_o,
  output logic [SIDE_W-1:0] side_o
);
  localparam int SHW  = $clog2(XLEN);
  localparam int CMAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam bit MUL_MC = (MUL_STAGES > 1);
  localparam logic [CW-1:0] DIV_LD = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_MC ? MUL_STAGES - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]     r_cnt;
  logic              r_valid, r_wb, r_br;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_res;
  logic [SIDE_W-1:0] r_side;
  logic              r_wb_c, r_br_c;
  logic [4:0]        r_rd_c;
  logic [SIDE_W-1:0] r_side_c;
  logic [XLEN-1:0]   r_mres, r_rem, r_quo, r_dvs;
  logic              r_qneg, r_rneg, r_isrem;

  // decode
  logic w_acc, w_alt, w_is_m, w_is_mul, w_is_div, w_single;
  assign in_ready = (r_state == S_IDLE) && !RST;
  assign w_acc    = in_valid && in_ready && !flush;
  assign w_alt    = (funct7 == 7'b0100000);
  assign w_is_m   = !imm && !branch_i && (funct7 == 7'b0000001);
  assign w_is_mul = w_is_m && !funct3[2];
  assign w_is_div = w_is_m && funct3[2];
  assign w_single = !w_is_div && !(w_is_mul && MUL_MC);

  // base ALU and branch compare
  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_base, w_sra;
  logic            w_lt, w_ltu, w_cond;
  assign w_sh  = op2[SHW-1:0];
  assign w_sra = $signed(op1) >>> w_sh;
  assign w_lt  = $signed(op1) < $signed(op2);
  assign w_ltu = op1 < op2;

  always_comb begin
    w_base = '0;
    unique case (funct3)
      3'b000: w_base = (!imm && w_alt) ? op1 - op2 : op1 + op2;
      3'b001: w_base = op1 << w_sh;
      3'b010: w_base = XLEN'(w_lt);
      3'b011: w_base = XLEN'(w_ltu);
      3'b100: w_base = op1 ^ op2;
      3'b101: w_base = w_alt ? w_sra : op1 >> w_sh;
      3'b110: w_base = op1 | op2;
      3'b111: w_base = op1 & op2;
      default: w_base = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    unique case (funct3)
      3'b000: w_cond = (op1 == op2);
      3'b001: w_cond = (op1 != op2);
      3'b100: w_cond = w_lt;
      3'b101: w_cond = !w_lt;
      3'b110: w_cond = w_ltu;
      3'b111: w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  // multiply: sign-extend to 2*XLEN, the low 2*XLEN product bits are exact
  logic              w_s1m, w_s2m;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0]   w_mres;
  assign w_s1m  = (funct3[1:0] != 2'b11) && op1[XLEN-1];
  assign w_s2m  = !funct3[1] && op2[XLEN-1];
  assign w_ma   = {{XLEN{w_s1m}}, op1};
  assign w_mb   = {{XLEN{w_s2m}}, op2};
  assign w_prod = w_ma * w_mb;
  assign w_mres = (funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                         : w_prod[2*XLEN-1:XLEN];

  // divide setup on magnitudes
  logic            w_n1, w_n2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  assign w_n1   = !funct3[0] && op1[XLEN-1];
  assign w_n2   = !funct3[0] && op2[XLEN-1];
  assign w_mag1 = w_n1 ? -op1 : op1;
  assign w_mag2 = w_n2 ? -op2 : op2;

  // restoring step; divisor 0 never borrows so q=all-ones, r=|op1|,
  // and min/-1 yields q=min, r=0 without extra handling
  logic [XLEN:0]   w_try, w_diff;
  logic [XLEN-1:0] w_qfix, w_rfix, w_dres;
  assign w_try  = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_try - {1'b0, r_dvs};
  assign w_qfix = r_qneg ? -r_quo : r_quo;
  assign w_rfix = r_rneg ? -r_rem : r_rem;
  assign w_dres = r_isrem ? w_rfix : w_qfix;

  logic            w_cz, w_fin;
  logic [XLEN-1:0] w_fres, w_sres;
  assign w_cz   = (r_cnt == '0);
  assign w_fin  = !flush && (((r_state == S_MUL) && w_cz) ||
                             (r_state == S_FIX));
  assign w_fres = (r_state == S_FIX) ? w_dres : r_mres;
  assign w_sres = branch_i ? XLEN'(w_cond) : (w_is_mul ? w_mres : w_base);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && w_is_div)
          w_next = S_DIV;
        else if (w_acc && w_is_mul && MUL_MC)
          w_next = S_MUL;
      end
      S_MUL:   if (w_cz) w_next = S_IDLE;
      S_DIV:   if (w_cz) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_wb     <= 1'b0;
      r_rd     <= '0;
      r_br     <= 1'b0;
      r_side   <= '0;
      r_wb_c   <= 1'b0;
      r_br_c   <= 1'b0;
      r_rd_c   <= '0;
      r_side_c <= '0;
      r_mres   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_isrem  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (r_state == S_MUL || r_state == S_DIV)
        r_cnt <= r_cnt - CW'(1);
      if (r_state == S_DIV) begin
        r_quo <= {r_quo[XLEN-2:0], !w_diff[XLEN]};
        r_rem <= w_diff[XLEN] ? w_try[XLEN-1:0] : w_diff[XLEN-1:0];
      end
      if (w_acc) begin
        r_wb_c   <= wb_i;
        r_br_c   <= branch_i;
        r_rd_c   <= rd_i;
        r_side_c <= side_i;
        r_cnt    <= w_is_div ? DIV_LD : MUL_LD;
        r_mres   <= w_mres;
        r_rem    <= '0;
        r_quo    <= w_mag1;
        r_dvs    <= w_mag2;
        r_qneg   <= (w_n1 ^ w_n2) && (op2 != '0);
        r_rneg   <= w_n1;
        r_isrem  <= funct3[1];
        if (w_single) begin
          r_valid <= 1'b1;
          r_res   <= w_sres;
          r_wb    <= wb_i;
          r_rd    <= rd_i;
          r_br    <= branch_i;
          r_side  <= side_i;
        end
      end
      if (w_fin) begin
        r_valid <= 1'b1;
        r_res   <= w_fres;
        r_wb    <= r_wb_c;
        r_rd    <= r_rd_c;
        r_br    <= r_br_c;
        r_side  <= r_side_c;
      end
    end
  end

  assign out_valid = r_valid;
  assign res       = r_res;
  assign wb_en_o   = r_valid && r_wb;
  assign rd_o      = r_valid ? r_rd : 5'd0;
  assign branch_o  = r_br;
  assign side_o    = r_side;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: drives two alu_md instances (XLEN=32/MUL_STAGES=2 and
// XLEN=64/MUL_STAGES=3) and compares against an arithmetic model.
module tb_alu_md;
  localparam logic [6:0] F7M = 7'b0000001;
  localparam logic [6:0] F7A = 7'b0100000;

  logic         CLK = 1'b0;
  logic         RST;
  logic         vA, vB, flush, imm, br, wb;
  logic [2:0]   f3;
  logic [6:0]   f7;
  logic [63:0]  op1, op2;
  logic [4:0]   rd;
  logic [107:0] side;

  logic         rdyA, ovA, wbA, brA;
  logic [31:0]  resA;
  logic [4:0]   rdA;
  logic [107:0] sideA;
  logic         rdyB, ovB, wbB, brB;
  logic [63:0]  resB;
  logic [4:0]   rdB;
  logic [107:0] sideB;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  alu_md #(.XLEN(32), .MUL_STAGES(2), .SIDE_W(108)) u_a (
    .CLK(CLK), .RST(RST), .in_valid(vA), .in_ready(rdyA),
    .flush(flush), .imm(imm), .branch_i(br), .funct3(f3),
    .funct7(f7), .op1(op1[31:0]), .op2(op2[31:0]), .rd_i(rd),
    .wb_i(wb), .side_i(side), .out_valid(ovA), .res(resA),
    .wb_en_o(wbA), .rd_o(rdA), .branch_o(brA), .side_o(sideA)
  );

  alu_md #(.XLEN(64), .MUL_STAGES(3), .SIDE_W(108)) u_b (
    .CLK(CLK), .RST(RST), .in_valid(vB), .in_ready(rdyB),
    .flush(flush), .imm(imm), .branch_i(br), .funct3(f3),
    .funct7(f7), .op1(op1), .op2(op2), .rd_i(rd),
    .wb_i(wb), .side_i(side), .out_valid(ovB), .res(resB),
    .wb_en_o(wbB), .rd_o(rdB), .branch_o(brB), .side_o(sideB)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_ov(int s);
    return (s != 0) ? ovB : ovA;
  endfunction
  function automatic logic f_rdy(int s);
    return (s != 0) ? rdyB : rdyA;
  endfunction
  function automatic logic [63:0] f_res(int s);
    return (s != 0) ? resB : {32'h0, resA};
  endfunction
  function automatic logic f_wb(int s);
    return (s != 0) ? wbB : wbA;
  endfunction
  function automatic logic [4:0] f_rd(int s);
    return (s != 0) ? rdB : rdA;
  endfunction
  function automatic logic f_br(int s);
    return (s != 0) ? brB : brA;
  endfunction
  function automatic logic [107:0] f_side(int s);
    return (s != 0) ? sideB : sideA;
  endfunction

  function automatic logic [63:0] model(int xl, logic [2:0] fn,
      logic [6:0] f7v, logic im, logic bv, logic [63:0] a,
      logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p, q, r;
    logic [63:0] m;
    int sh;
    m  = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    ua = {64'h0, a & m};
    ub = {64'h0, b & m};
    sa = (xl == 32) ? {{96{a[31]}}, a[31:0]} : {{64{a[63]}}, a};
    sb = (xl == 32) ? {{96{b[31]}}, b[31:0]} : {{64{b[63]}}, b};
    sh = int'(b[5:0]) % xl;
    if (bv) begin
      case (fn)
        3'd0: return 64'(sa == sb);
        3'd1: return 64'(sa != sb);
        3'd4: return 64'(sa < sb);
        3'd5: return 64'(sa >= sb);
        3'd6: return 64'(ua < ub);
        3'd7: return 64'(ua >= ub);
        default: return 64'h0;
      endcase
    end
    if (!im && f7v == F7M) begin
      if (!fn[2]) begin
        p = ((fn[1:0] == 2'b11) ? ua : sa) * ((fn[1] == 1'b0) ? sb : ub);
        if (fn[1:0] != 2'b00) p = p >>> xl;
        return p[63:0] & m;
      end
      if (ub == 0) begin
        q = '1;
        r = ua;
      end else if (!fn[0]) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      return (fn[1] ? r[63:0] : q[63:0]) & m;
    end
    case (fn)
      3'd0: return ((!im && f7v == F7A) ? a - b : a + b) & m;
      3'd1: return (a << sh) & m;
      3'd2: return 64'(sa < sb);
      3'd3: return 64'(ua < ub);
      3'd4: return (a ^ b) & m;
      3'd5: begin
        p = (f7v == F7A) ? (sa >>> sh) : (ua >> sh);
        return p[63:0] & m;
      end
      3'd6: return (a | b) & m;
      default: return (a & b) & m;
    endcase
  endfunction

  function automatic int exp_lat(int s, logic [2:0] fn, logic [6:0] f7v,
                                 logic im, logic bv);
    if (im || bv || f7v != F7M) return 1;
    if (fn[2]) return (s != 0) ? 66 : 34;
    return (s != 0) ? 3 : 2;
  endfunction

  function automatic logic [63:0] rnd_op(int s);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = 64'h0;
      1: v = '1;
      2: v = (s != 0) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: v = 64'($urandom_range(0, 20));
      4: v = -64'($urandom_range(1, 5));
      default: ;
    endcase
    return v;
  endfunction

  task automatic issue(input int s, input logic [2:0] fn,
      input logic [6:0] f7v, input logic im, input logic bv,
      input logic [63:0] a, input logic [63:0] b);
    logic [127:0] t;
    @(negedge CLK);
    check("rdy_pre", 128'(f_rdy(s)), 128'd1);
    t    = {$urandom, $urandom, $urandom, $urandom};
    side = t[107:0];
    rd   = 5'($urandom);
    wb   = 1'($urandom);
    f3 = fn; f7 = f7v; imm = im; br = bv; op1 = a; op2 = b;
    vA = (s == 0);
    vB = (s != 0);
    @(negedge CLK);
    vA = 1'b0;
    vB = 1'b0;
  endtask

  task automatic run(input int s, input logic [2:0] fn,
      input logic [6:0] f7v, input logic im, input logic bv,
      input logic [63:0] a, input logic [63:0] b,
      output logic [63:0] got);
    logic [63:0] e;
    int n, el;
    e  = model((s != 0) ? 64 : 32, fn, f7v, im, bv, a, b);
    el = exp_lat(s, fn, f7v, im, bv);
    issue(s, fn, f7v, im, bv, a, b);
    n = 1;
    while (!f_ov(s) && n < 100) begin
      check("busy", 128'(f_rdy(s)), 128'd0);
      @(negedge CLK);
      n++;
    end
    got = f_res(s);
    check("lat", 128'(n), 128'(el));
    check("res", 128'(got), 128'(e));
    check("wb", 128'(f_wb(s)), 128'(wb));
    check("rd", 128'(f_rd(s)), 128'(rd));
    check("br", 128'(f_br(s)), 128'(bv));
    check("side", 128'(f_side(s)), 128'(side));
    check("rdy_out", 128'(f_rdy(s)), 128'd1);
    @(negedge CLK);
    check("pulse", 128'(f_ov(s)), 128'd0);
    check("bub_rd", 128'(f_rd(s)), 128'd0);
    check("bub_wb", 128'(f_wb(s)), 128'd0);
    check("hold", 128'(f_res(s)), 128'(e));
  endtask

  task automatic dir(input string tag, input int s, input logic [2:0] fn,
      input logic [6:0] f7v, input logic bv, input logic [63:0] a,
      input logic [63:0] b, input logic [63:0] e);
    logic [63:0] got;
    run(s, fn, f7v, 1'b0, bv, a, b, got);
    check(tag, 128'(got), 128'(e));
  endtask

  initial begin
    logic [63:0] got;
    int seen;
    RST = 1'b1; vA = 0; vB = 0; flush = 0; imm = 0; br = 0; wb = 0;
    f3 = 0; f7 = 0; op1 = 0; op2 = 0; rd = 0; side = '0;
    repeat (3) @(negedge CLK);
    check("rst_rdyA", 128'(rdyA), 128'd0);
    check("rst_ovA", 128'(ovA), 128'd0);
    check("rst_resA", 128'(resA), 128'd0);
    check("rst_wbA", 128'(wbA), 128'd0);
    check("rst_rdA", 128'(rdA), 128'd0);
    check("rst_brA", 128'(brA), 128'd0);
    check("rst_sideA", 128'(sideA), 128'd0);
    check("rst_rdyB", 128'(rdyB), 128'd0);
    check("rst_resB", 128'(resB), 128'd0);
    RST = 1'b0;

    dir("add", 0, 3'd0, 7'd0, 0, 64'd5, -64'd3, 64'd2);
    dir("sub", 0, 3'd0, F7A, 0, 64'd5, 64'd7, 64'hFFFF_FFFE);
    dir("sra", 0, 3'd5, F7A, 0, 64'h8000_0000, 64'd4, 64'hF800_0000);
    dir("bltu", 0, 3'd6, 7'd0, 1, 64'd1, 64'hFFFF_FFFF, 64'd1);
    dir("blt", 0, 3'd4, 7'd0, 1, 64'd1, 64'hFFFF_FFFF, 64'd0);
    dir("beq", 0, 3'd0, 7'd0, 1, 64'd7, 64'd7, 64'd1);
    dir("mulh", 0, 3'd1, F7M, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0);
    dir("mulhu", 0, 3'd3, F7M, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
        64'hFFFF_FFFE);
    dir("mul", 0, 3'd0, F7M, 0, 64'd3, -64'd4, 64'hFFFF_FFF4);
    dir("div", 0, 3'd4, F7M, 0, -64'd7, 64'd2, 64'hFFFF_FFFD);
    dir("rem", 0, 3'd6, F7M, 0, -64'd7, 64'd2, 64'hFFFF_FFFF);
    dir("divu0", 0, 3'd5, F7M, 0, 64'd100, 64'd0, 64'hFFFF_FFFF);
    dir("rem0", 0, 3'd6, F7M, 0, 64'd100, 64'd0, 64'd100);
    dir("ovf", 0, 3'd4, F7M, 0, 64'h8000_0000, 64'hFFFF_FFFF,
        64'h8000_0000);
    dir("div64", 1, 3'd4, F7M, 0, -64'd7, 64'd2, -64'd3);
    dir("mul64", 1, 3'd0, F7M, 0, 64'd3, -64'd4, 64'hFFFF_FFFF_FFFF_FFF4);
    dir("mulhu64", 1, 3'd3, F7M, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    dir("ovf64", 1, 3'd4, F7M, 0, 64'h8000_0000_0000_0000, '1,
        64'h8000_0000_0000_0000);

    // divide killed by flush ten cycles after accept
    issue(0, 3'd4, F7M, 0, 0, 64'd1000, 64'd3);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("fl_ov", 128'(ovA), 128'd0);
    check("fl_rdy", 128'(rdyA), 128'd1);
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (ovA) seen++;
    end
    check("fl_quiet", 128'(seen), 128'd0);
    dir("add_fl", 0, 3'd0, 7'd0, 0, 64'd40, 64'd2, 64'd42);

    // op presented together with flush is dropped
    @(negedge CLK);
    f3 = 0; f7 = 0; imm = 0; br = 0; op1 = 1; op2 = 1; vA = 1'b1;
    flush = 1'b1;
    @(negedge CLK);
    vA = 1'b0;
    flush = 1'b0;
    check("flop_ov", 128'(ovA), 128'd0);
    check("flop_rdy", 128'(rdyA), 128'd1);

    // reset in the middle of a 64-bit divide
    issue(1, 3'd5, F7M, 0, 0, 64'd12345, 64'd7);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_rdy", 128'(rdyB), 128'd0);
    check("mrst_ov", 128'(ovB), 128'd0);
    check("mrst_res", 128'(resB), 128'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("mrst_rdy2", 128'(rdyB), 128'd1);
    seen = 0;
    repeat (70) begin
      @(negedge CLK);
      if (ovB) seen++;
    end
    check("mrst_quiet", 128'(seen), 128'd0);

    for (int i = 0; i < 200; i++) begin
      int s, c;
      logic [2:0] fn;
      logic [6:0] f7v;
      logic im, bv;
      s = i & 1;
      c = $urandom_range(0, 3);
      fn = 3'($urandom);
      f7v = 7'd0;
      im = 1'b0;
      bv = 1'b0;
      case (c)
        0: begin
          im = 1'($urandom);
          case ($urandom_range(0, 2))
            0: f7v = F7A;
            1: f7v = im ? F7M : 7'd0;
            default: f7v = 7'd0;
          endcase
        end
        1: begin
          bv = 1'b1;
          f7v = 1'($urandom) ? F7M : 7'd0;
        end
        2: begin
          f7v = F7M;
          fn[2] = 1'b0;
        end
        default: begin
          f7v = F7M;
          fn[2] = 1'b1;
        end
      endcase
      run(s, fn, f7v, im, bv, rnd_op(s), rnd_op(s), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
